// File: rtl/hack_data_mem_if.sv
// hack_data_mem_if: CPU data-port, keyboard and screen-update signals for
// hack_data_mem.
//   master : CPU/system side (drives addr/wdata/we, kbd_*, scr_ready)
//   slave  : memory side (drives rdata, scr_valid/offset/data, scr_ovf, err)
//
// Signals:
//   addr/wdata/we       CPU data address, write data, write enable
//   rdata               combinational read data from addr
//   kbd_valid/kbd_code  one-cycle key-code strobe and code (0 = released)
//   scr_valid/ready     screen-update FIFO head valid / display accept
//   scr_offset/data     head entry: screen word offset and pixel word
//   scr_ovf             sticky: a screen update was dropped
//   err                 sticky bad-access flag (0 unless bounds checking built)
interface hack_data_mem_if;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        we;
  logic [15:0] rdata;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic        scr_valid;
  logic [12:0] scr_offset;
  logic [15:0] scr_data;
  logic        scr_ready;
  logic        scr_ovf;
  logic        err;

  modport master (
    output addr, wdata, we, kbd_valid, kbd_code, scr_ready,
    input  rdata, scr_valid, scr_offset, scr_data, scr_ovf, err
  );

  modport slave (
    input  addr, wdata, we, kbd_valid, kbd_code, scr_ready,
    output rdata, scr_valid, scr_offset, scr_data, scr_ovf, err
  );
endinterface

// File: rtl/hack_data_mem.sv
// hack_data_mem: Hack CPU data-memory responder. Decodes the Hack memory map
// (general RAM, screen, keyboard register), answers reads combinationally
// and forwards every screen write to an external display through a small
// valid/ready FIFO.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous, active-high
//   bus    hack_data_mem_if.slave (CPU port, keyboard input, screen FIFO out)
//
// Build option: define HACK_MEM_BOUNDS_EN to enable the sticky err flag
// (writes to the keyboard register and any access to unmapped addresses).
// Without it err is tied low and no checking logic exists.
module hack_data_mem #(
  parameter int RAM_WORDS  = 16384,
  parameter int SCR_BASE   = 16384,
  parameter int SCR_WORDS  = 8192,
  parameter int KBD_ADDR   = 24576,
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  hack_data_mem_if.slave bus
);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCR_WORDS);
  localparam int PW     = $clog2(FIFO_DEPTH);

  logic [15:0] ram      [RAM_WORDS];
  logic [15:0] scrMem   [SCR_WORDS];
  logic [12:0] fifoOff  [FIFO_DEPTH];
  logic [15:0] fifoData [FIFO_DEPTH];

  logic [PW-1:0] rdPtr, wrPtr;
  logic [PW:0]   count;
  logic          ovfReg;
  logic [15:0]   kbdReg;

  // Decode on a 17-bit copy so SCR_BASE+SCR_WORDS cannot wrap.
  logic [16:0]       addrExt;
  logic              isRam, isScr, isKbd, isUnmapped;
  logic [RAM_AW-1:0] ramIdx;
  logic [SCR_AW-1:0] scrIdx;

  assign addrExt    = {1'b0, bus.addr};
  assign isRam      = addrExt < 17'(RAM_WORDS);
  assign isScr      = (addrExt >= 17'(SCR_BASE)) && (addrExt < 17'(SCR_BASE + SCR_WORDS));
  assign isKbd      = addrExt == 17'(KBD_ADDR);
  assign isUnmapped = !(isRam || isScr || isKbd);
  assign ramIdx     = bus.addr[RAM_AW-1:0];
  assign scrIdx     = SCR_AW'(bus.addr - 16'(SCR_BASE));

  logic full, push, pushOk, popOk, drop;

  assign full   = count == (PW+1)'(FIFO_DEPTH);
  assign push   = bus.we && isScr && !reset;
  assign popOk  = (count != '0) && bus.scr_ready && !reset;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign pushOk = push && (!full || popOk);
  assign drop   = push && full && !popOk;

  always_comb begin
    bus.rdata = '0;
    if (isRam)      bus.rdata = ram[ramIdx];
    else if (isScr) bus.rdata = scrMem[scrIdx];
    else if (isKbd) bus.rdata = kbdReg;
  end

  assign bus.scr_valid  = count != '0;
  assign bus.scr_offset = fifoOff[rdPtr];
  assign bus.scr_data   = fifoData[rdPtr];
  assign bus.scr_ovf    = ovfReg;

  // Storage arrays: not reset; writes are blocked on a reset edge.
  always_ff @(posedge clk) begin
    if (!reset && bus.we) begin
      if (isRam) ram[ramIdx]    <= bus.wdata;
      if (isScr) scrMem[scrIdx] <= bus.wdata;
    end
    if (pushOk) begin
      fifoOff[wrPtr]  <= 13'(scrIdx);
      fifoData[wrPtr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      count  <= '0;
      ovfReg <= 1'b0;
      kbdReg <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      case ({pushOk, popOk})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)          ovfReg <= 1'b1;
      if (bus.kbd_valid) kbdReg <= bus.kbd_code;
    end
  end

`ifdef HACK_MEM_BOUNDS_EN
  logic errReg;
  always_ff @(posedge clk) begin
    if (reset)                                  errReg <= 1'b0;
    else if ((bus.we && isKbd) || isUnmapped)   errReg <= 1'b1;
  end
  assign bus.err = errReg;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_hack_data_mem.sv
module tb_hack_data_mem;
`ifdef HACK_MEM_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hack_data_mem_if bus();

  hack_data_mem #(
    .RAM_WORDS (16384),
    .SCR_BASE  (16384),
    .SCR_WORDS (8192),
    .KBD_ADDR  (24576),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int nTests = 0;
  int nFail  = 0;

  // Scoreboard: expected screen-FIFO entries {offset, data} in order.
  logic [28:0] expQ[$];
  bit          ovfExp = 1'b0;
  bit          errExp = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Update the reference model from the inputs about to be sampled, then
  // advance one clock and settle.
  task automatic tick();
    int a;
    bit isScr, isKbd, unm;
    logic [28:0] head;
    a     = int'(bus.addr);
    isScr = (a >= 16384) && (a < 24576);
    isKbd = (a == 24576);
    unm   = (a >= 24577);
    checkVal("scrValid", bus.scr_valid, expQ.size() != 0);
    if (reset) begin
      expQ.delete();
      ovfExp = 1'b0;
      errExp = 1'b0;
    end else begin
      bit popping;
      popping = bus.scr_ready && (expQ.size() != 0);
      if (popping) begin
        head = expQ.pop_front();
        checkVal("headOffset", bus.scr_offset, head[28:16]);
        checkVal("headData",   bus.scr_data,   head[15:0]);
      end
      if (bus.we && isScr) begin
        if (expQ.size() < 4) expQ.push_back({13'(a - 16384), bus.wdata});
        else                 ovfExp = 1'b1;
      end
      if (BOUNDS && ((bus.we && isKbd) || unm)) errExp = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic rdCheck(input string tag, input logic [15:0] a, input logic [15:0] exp);
    bus.addr = a;
    #1;
    checkVal(tag, bus.rdata, exp);
  endtask

  task automatic drain(input int n);
    bus.scr_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    bus.scr_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.addr = '0; bus.wdata = '0; bus.we = 1'b0;
    bus.kbd_valid = 1'b0; bus.kbd_code = '0; bus.scr_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    checkVal("rstScrValid", bus.scr_valid, 0);
    checkVal("rstOvf", bus.scr_ovf, 0);
    checkVal("rstErr", bus.err, 0);
    rdCheck("rstKbd", 16'd24576, 16'h0000);

    // RAM round trips and read-before-write
    wr(16'd100, 16'h1234);
    rdCheck("ram100", 16'd100, 16'h1234);
    bus.wdata = 16'h5678; bus.we = 1'b1;
    #1;
    checkVal("ramRbw", bus.rdata, 16'h1234);
    tick(); bus.we = 1'b0;
    rdCheck("ram100b", 16'd100, 16'h5678);
    wr(16'd16383, 16'hFFFF);
    rdCheck("ramTop", 16'd16383, 16'hFFFF);

    // Screen writes queued, then popped in order
    wr(16'd16384, 16'hAAAA);
    wr(16'd24575, 16'h5555);
    checkVal("scrValid1", bus.scr_valid, 1);
    checkVal("head0Off", bus.scr_offset, 0);
    checkVal("head0Data", bus.scr_data, 16'hAAAA);
    tick();
    checkVal("headStableOff", bus.scr_offset, 0);
    checkVal("headStableData", bus.scr_data, 16'hAAAA);
    drain(2);
    checkVal("scrEmpty", bus.scr_valid, 0);
    rdCheck("shadowLo", 16'd16384, 16'hAAAA);
    rdCheck("shadowHi", 16'd24575, 16'h5555);

    // Overflow: 5 writes into a 4-deep FIFO
    for (int i = 0; i < 5; i++) wr(16'(16384 + i), 16'(16'h0100 + i));
    checkVal("ovfSet", bus.scr_ovf, 1);
    checkVal("ovfModel", bus.scr_ovf, ovfExp);
    rdCheck("shadowDropped", 16'd16388, 16'h0104);
    // Full FIFO: push and pop on the same edge
    bus.scr_ready = 1'b1;
    wr(16'd16400, 16'hBEEF);
    bus.scr_ready = 1'b0;
    checkVal("fullPushPopCnt", expQ.size(), 4);
    drain(4);
    checkVal("drainedEmpty", bus.scr_valid, 0);

    // Empty FIFO: push and pop on the same edge -> only push
    bus.scr_ready = 1'b1;
    wr(16'd16390, 16'h0777);
    bus.scr_ready = 1'b0;
    checkVal("emptyPushPopValid", bus.scr_valid, 1);
    checkVal("emptyPushPopData", bus.scr_data, 16'h0777);
    drain(1);

    // Keyboard register
    bus.addr = 16'd24576; bus.kbd_valid = 1'b1; bus.kbd_code = 16'd65;
    #1;
    checkVal("kbdOldSameCycle", bus.rdata, 0);
    tick();
    bus.kbd_valid = 1'b0;
    rdCheck("kbd65", 16'd24576, 16'd65);
    wr(16'd24576, 16'd7);
    rdCheck("kbdReadOnly", 16'd24576, 16'd65);
    checkVal("errKbdWrite", bus.err, errExp);
    bus.kbd_valid = 1'b1; bus.kbd_code = 16'd0;
    tick();
    bus.kbd_valid = 1'b0;
    rdCheck("kbdRelease", 16'd24576, 16'd0);

    // Reset mid-operation
    checkVal("ovfSticky", bus.scr_ovf, 1);
    for (int i = 0; i < 3; i++) wr(16'(16500 + i), 16'(16'h0200 + i));
    bus.kbd_valid = 1'b1; bus.kbd_code = 16'd9;
    tick();
    bus.kbd_valid = 1'b0;
    rdCheck("kbd9", 16'd24576, 16'd9);
    reset = 1'b1;
    bus.addr = 16'd100; bus.wdata = 16'hDEAD; bus.we = 1'b1;
    tick();
    reset = 1'b0; bus.we = 1'b0;
    checkVal("midRstValid", bus.scr_valid, 0);
    checkVal("midRstOvf", bus.scr_ovf, 0);
    checkVal("midRstErr", bus.err, 0);
    rdCheck("midRstKbd", 16'd24576, 16'd0);
    rdCheck("midRstRam", 16'd100, 16'h5678);
    rdCheck("midRstRamTop", 16'd16383, 16'hFFFF);

    // Unmapped access
    bus.addr = 16'h7000;
    #1;
    checkVal("unmappedRd", bus.rdata, 0);
    tick();
    checkVal("errUnmapped", bus.err, BOUNDS);
    bus.addr = 16'd100;
    tick(); tick();
    checkVal("errSticky", bus.err, BOUNDS);
    checkVal("errModel", bus.err, errExp);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkVal("errCleared", bus.err, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
